// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI flash arbiter and its power timer.
package spi_mem_pkg;

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ST_W   = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_OFF   = 3'd0;
  localparam state_t ST_PWRUP = 3'd1;
  localparam state_t ST_IDLE  = 3'd2;
  localparam state_t ST_ISSUE = 3'd3;
  localparam state_t ST_BUSY  = 3'd4;
  localparam state_t ST_ZLEN  = 3'd5;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam logic [CMD_W-1:0] OP_WREN = 8'h06;
  localparam logic [CMD_W-1:0] OP_PP   = 8'h02;
  localparam logic [CMD_W-1:0] OP_READ = 8'h03;
  localparam logic [CMD_W-1:0] OP_RDID = 8'h9F;
  localparam logic [CMD_W-1:0] OP_SE   = 8'h20;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } mem_cmd_t;

endpackage

// File: rtl/spi_mem_pwr_timer.sv
// Shared cycle counter with clear, enable and terminal-count compare.
module spi_mem_pwr_timer #(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == tc_val);

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-requester arbiter in front of the SPI flash master; also sequences
// memory power (settle after power-up, power-down after a long idle).
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 2000,
  parameter int unsigned IDLE_TIMEOUT = 200000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [CMD_W-1:0]  a_cmd,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [LEN_W-1:0]  a_len,
  output logic              a_gnt,
  output logic              a_done,
  input  logic              b_req,
  input  logic [CMD_W-1:0]  b_cmd,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  output logic              b_gnt,
  output logic              b_done,
  output logic              m_valid,
  output logic [CMD_W-1:0]  m_cmd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  input  logic              m_ready,
  input  logic              m_done,
  output logic              mem_vcc,
  output logic              mem_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] PWR_TC  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(IDLE_TIMEOUT - 1);
  localparam bit               IDLE_PD = (IDLE_TIMEOUT != 0);

  state_t   state_q, state_d;
  owner_e   owner_q, owner_d;
  owner_e   last_q, last_d;
  mem_cmd_t cmd_q, cmd_d;
  logic     m_valid_q, m_valid_d;
  logic     a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic     a_done_q, a_done_d, b_done_q, b_done_d;
  logic     mem_vcc_q, mem_vcc_d, mem_ready_q, mem_ready_d, busy_q, busy_d;

  logic             win_a_c;
  logic             timer_clr_c, timer_en_c, timer_tc_c;
  logic [CNT_W-1:0] timer_tc_val_c;
  mem_cmd_t         a_pkt_c, b_pkt_c;

  assign a_pkt_c = {a_cmd, a_addr, a_len};
  assign b_pkt_c = {b_cmd, b_addr, b_len};

  // Round-robin: on a tie the requester that was not served last wins.
  assign win_a_c = a_req && (!b_req || (last_q == OWN_B));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (a_req || b_req) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (timer_tc_c) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (a_req || b_req) begin
          owner_d = win_a_c ? OWN_A : OWN_B;
          last_d  = owner_d;
          cmd_d   = win_a_c ? a_pkt_c : b_pkt_c;
          a_gnt_d = win_a_c;
          b_gnt_d = !win_a_c;
          state_d = (cmd_d.len == '0) ? ST_ZLEN : ST_ISSUE;
        end else if (IDLE_PD && timer_tc_c) begin
          state_d = ST_OFF;
        end
      end
      ST_ISSUE: begin
        if (m_ready) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (m_done) begin
          state_d  = ST_IDLE;
          a_done_d = (owner_q == OWN_A);
          b_done_d = (owner_q == OWN_B);
        end
      end
      ST_ZLEN: begin
        state_d  = ST_IDLE;
        a_done_d = (owner_q == OWN_A);
        b_done_d = (owner_q == OWN_B);
      end
      default: state_d = ST_OFF;
    endcase

    mem_vcc_d   = (state_d != ST_OFF);
    mem_ready_d = (state_d == ST_IDLE) || (state_d == ST_ISSUE) || (state_d == ST_BUSY);
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_BUSY);
    m_valid_d   = (state_d == ST_ISSUE);
  end

  // Timer restarts on every state change, so each PWRUP/IDLE stay counts from zero.
  assign timer_clr_c    = (state_d != state_q);
  assign timer_en_c     = (state_q == ST_PWRUP) || (state_q == ST_IDLE);
  assign timer_tc_val_c = (state_q == ST_PWRUP) ? PWR_TC : IDLE_TC;

  spi_mem_pwr_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr_c),
    .en     (timer_en_c),
    .tc_val (timer_tc_val_c),
    .tc_c   (timer_tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      owner_q     <= OWN_A;
      last_q      <= OWN_B;
      cmd_q       <= '0;
      m_valid_q   <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      mem_vcc_q   <= 1'b0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      m_valid_q   <= m_valid_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      mem_vcc_q   <= mem_vcc_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign m_valid   = m_valid_q;
  assign m_cmd     = cmd_q.cmd;
  assign m_addr    = cmd_q.addr;
  assign m_len     = cmd_q.len;
  assign mem_vcc   = mem_vcc_q;
  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Shares the single SPI flash master between two requesters: port A is the UART command path and port B is the pushbutton test sequencer. The block also owns memory power sequencing. It drives MEM_VCC, waits a power-up settle time, and only then hands transactions to the SPI master. After a long idle period it removes power again. It sits between the requesters and the SPI master inside top, and it drives the MEM_VCC and MEM_CM_READY pins.

Parameters:
PWRUP_CYCLES, 2000, clk cycles from mem_vcc rising to memory usable (100 us at 20 MHz)
IDLE_TIMEOUT, 200000, idle clk cycles in IDLE before power-down; 0 disables power-down
CNT_W, 18, width of the shared timer counter; must hold max(PWRUP_CYCLES, IDLE_TIMEOUT)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
a_req  in  1  requester A wants a transaction; held high until a_gnt
a_cmd  in  8  requester A SPI opcode
a_addr  in  24  requester A flash address
a_len  in  16  requester A data byte count
a_gnt  out  1  one-cycle pulse: A's fields are latched
a_done  out  1  one-cycle pulse: A's transaction is complete
b_req, b_cmd, b_addr, b_len, b_gnt, b_done  same as the A ports, for requester B
m_valid  out  1  command valid to the SPI master
m_cmd  out  8  latched opcode
m_addr  out  24  latched address
m_len  out  16  latched length
m_ready  in  1  master accepts the command while m_valid is high
m_done  in  1  one-cycle pulse from master: transaction finished
mem_vcc  out  1  memory supply enable (MEM_VCC)
mem_ready  out  1  high in IDLE/ISSUE/BUSY (MEM_CM_READY)
busy  out  1  high in ISSUE or BUSY

Behaviour:
- Reset (async, rst_n=0):
  - state=OFF.
  - All outputs are 0, including mem_vcc, m_valid, gnt/done and the m_* fields.
  - last_grant=B, so A wins the first tie.
  - timer=0.
- States: OFF, PWRUP, IDLE, ISSUE, BUSY, ZLEN.
- OFF:
  - mem_vcc=0.
  - If a_req or b_req is high: mem_vcc goes to 1 next cycle, timer is cleared, go to PWRUP. Requests are not granted here.
- PWRUP:
  - mem_vcc=1. Timer increments each cycle.
  - When timer==PWRUP_CYCLES-1, go to IDLE.
  - mem_ready rises on the first IDLE cycle.
- IDLE:
  - If any request is present, arbitrate in the same cycle:
    - Single requester wins.
    - If both request, the one not equal to last_grant wins (round-robin).
  - On a win:
    - Latch the winner's cmd/addr/len into the m_* registers.
    - Pulse the winner's gnt for exactly 1 cycle, on the IDLE→next-state transition edge.
    - Update last_grant.
    - If len!=0, go to ISSUE; if len==0, go to ZLEN.
  - With no request, the idle timer increments.
  - If IDLE_TIMEOUT!=0 and timer==IDLE_TIMEOUT-1, go to OFF. mem_vcc and mem_ready drop next cycle.
  - A request in the same cycle as the timeout wins: grant proceeds, no power-down, timer is cleared.
  - The timer clears on every grant.
- ISSUE:
  - m_valid=1, m_* stable.
  - On m_ready=1, m_valid drops next cycle and state goes to BUSY.
  - m_done in ISSUE is ignored (protocol violation).
- BUSY:
  - Wait for m_done.
  - On m_done, pulse the owner's done for 1 cycle (next cycle), then go to IDLE.
  - m_ready is ignored here.
- ZLEN:
  - Zero-length transaction; the master is never invoked.
  - Pulse the owner's done for 1 cycle, then go to IDLE. The done pulse comes the cycle after gnt.
- Requester rules:
  - A requester must drop req after gnt.
  - If req is still high in the IDLE cycle after done, it is treated as a new request.
  - At most one of a_gnt/b_gnt is high in any cycle, and the same holds for a_done/b_done.
- The owner ID is registered at grant and selects the done pulse. Requests arriving in ISSUE/BUSY wait; the pending requester is served on the next IDLE cycle.
- Reset mid-transaction: immediate return to OFF and mem_vcc=0. No done pulse is issued. The master is reset by the same rst_n.

Decomposition:
- Package spi_mem_pkg:
  - state enum.
  - owner enum {OWN_A, OWN_B}.
  - Opcode constants: OP_WREN=8'h06, OP_PP=8'h02, OP_READ=8'h03, OP_RDID=8'h9F, OP_SE=8'h20.
  - Width localparams: ADDR_W=24, LEN_W=16.
- Sub-module spi_mem_pwr_timer: CNT_W-bit counter with clear, enable and a terminal-count compare. It is shared by PWRUP and the idle timeout.

Test Plan:
(Bench uses PWRUP_CYCLES=4, IDLE_TIMEOUT=16.)
- Cold start: rst_n pulse, then a_req=1, a_cmd=8'h9F, a_len=3.
  - Required: mem_vcc rises 1 cycle later and mem_ready rises 4 cycles after that.
  - Then a_gnt pulses once, m_valid=1 with m_cmd=8'h9F, m_len=3.
  - m_ready=1 → m_valid=0 next cycle. m_done pulse → a_done pulses next cycle.
- Simultaneous: a_req and b_req both high in IDLE, last_grant=B.
  - Required: A is granted first. B is granted on the first IDLE cycle after a_done. Grant order A,B,A over three rounds with both held.
- Zero length: b_len=0, b_req=1.
  - Required: b_gnt, then b_done the next cycle. m_valid never asserts.
- Idle power-down: no requests for 16 IDLE cycles.
  - Required: mem_vcc=0 and mem_ready=0.
  - A later a_req reproduces the 1+4-cycle power-up before a_gnt.
- Timeout collision: a_req rises in exactly the 16th idle cycle.
  - Required: a_gnt pulses, mem_vcc stays 1.
- Reset mid-BUSY: assert rst_n=0 while waiting on m_done.
  - Required: mem_vcc, m_valid and busy are 0 immediately. No a_done/b_done pulse. State is OFF after release.
